// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for an RV64I subset (R, I-arith, load, store, BEQ); outputs decoded from state.
// Zero-wait latency R/I 4, load 5, store 4, branch 3; stalls on imem/dmem ready, aborts to IDLE on wait timeout.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic [1:0]       imm_sel,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           retire;
  logic           timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_st, is_br, legal;
  logic       unused_instr_bits;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_ld  = (opcode == 7'b0000011);
  assign is_st  = (opcode == 7'b0100011);
  assign is_br  = (opcode == 7'b1100011);
  assign legal  = is_r | is_i | is_ld | is_st | is_br;
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  assign imm_sel = instruction[6:5];
  assign state   = state_q;

  // The wait cycle that would make the count reach the limit is the abort cycle, unless ready arrives on it.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (int'(wait_q) == MEM_TIMEOUT - 1);

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          bus_error = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_instr = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_op  = 2'b10;
          state_d = S_WB;
        end else if (is_i) begin
          alu_src = 1'b1;
          alu_op  = 2'b10;
          state_d = S_WB;
        end else if (is_ld || is_st) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (is_br) begin
          alu_op = 2'b01;
          if (funct3 == 3'b000 && zero) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          dmem_we = is_st;
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout_hit) begin
          // Write strobe withheld so an aborted store cannot land late.
          bus_error = 1'b1;
          state_d   = S_IDLE;
        end else begin
          dmem_we = is_st;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
      wait_d = '0;
    end else if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      instret <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) begin
        instret <= instret + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: table vectors, hand sequences and random episodes against a per-instruction model.
module tb_multicycle_control_fsm;
  localparam int T  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   instruction;
  logic          zero, imem_ready, dmem_ready;
  logic          imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic          reg_write, alu_src, mem_to_reg, illegal_instr, bus_error;
  logic [1:0]    alu_op, imm_sel;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_instret = 0;
  int trace[$];

  typedef struct {
    int cycles, irw, pcw, pcsrc, regw, m2r, dreq, dwe, ill, berr, ret, idle;
  } res_t;

  typedef struct {
    logic [31:0] ins;
    bit          z;
    int          di, dd;
    res_t        exp;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .imm_sel(imm_sel), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .state(state), .instret(instret)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] opc);
    return opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 || opc == 7'h63;
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input bit z, input int di, input int dd,
                              input int cyc, input int irw, input int pcw, input int pcsrc,
                              input int regw, input int m2r, input int dreq, input int dwe,
                              input int ill, input int berr, input int ret, input int idle);
    vec_t v;
    v.ins = ins; v.z = z; v.di = di; v.dd = dd;
    v.exp.cycles = cyc; v.exp.irw = irw; v.exp.pcw = pcw; v.exp.pcsrc = pcsrc;
    v.exp.regw = regw; v.exp.m2r = m2r; v.exp.dreq = dreq; v.exp.dwe = dwe;
    v.exp.ill = ill; v.exp.berr = berr; v.exp.ret = ret; v.exp.idle = idle;
    return v;
  endfunction

  // Per-instruction model: cycle budget and event counts derived from the phase lengths.
  function automatic res_t model(input logic [31:0] ins, input bit z, input int di, input int dd);
    res_t m;
    m = '{default: 0};
    if (di >= T) begin
      m.cycles = T; m.berr = 1; m.idle = 1;
      return m;
    end
    m.cycles = di + 1; m.irw = 1; m.pcw = 1;
    case (ins[6:0])
      7'h33, 7'h13: begin m.cycles += 3; m.regw = 1; m.ret = 1; end
      7'h03: begin
        if (dd >= T) begin m.cycles += 2 + T; m.dreq = T; m.berr = 1; m.idle = 1; end
        else begin m.cycles += 2 + dd + 1 + 1; m.dreq = dd + 1; m.regw = 1; m.m2r = 1; m.ret = 1; end
      end
      7'h23: begin
        if (dd >= T) begin m.cycles += 2 + T; m.dreq = T; m.dwe = T - 1; m.berr = 1; m.idle = 1; end
        else begin m.cycles += 2 + dd + 1; m.dreq = dd + 1; m.dwe = dd + 1; m.ret = 1; end
      end
      7'h63: begin
        m.cycles += 2; m.ret = 1;
        if (ins[14:12] == 3'b000 && z) begin m.pcw += 1; m.pcsrc = 1; end
      end
      default: begin m.cycles += 1; m.ill = 1; end
    endcase
    return m;
  endfunction

  // Runs one instruction starting in FETCH (called at a falling edge) until it returns to FETCH or IDLE.
  task automatic run_episode(input logic [31:0] ins, input bit z, input int di, input int dd,
                             output res_t r);
    int icnt = 0;
    int dcnt = 0;
    bit done = 0;
    logic [2:0] st;
    logic [CW-1:0] i0, d;
    r = '{default: 0};
    trace.delete();
    instruction = ins;
    zero = z;
    i0 = instret;
    for (int c = 0; c < 64 && !done; c++) begin
      imem_ready = imem_req && (icnt >= di);
      dmem_ready = dmem_req && (dcnt >= dd);
      #1;
      st = state;
      trace.push_back(int'(st));
      check("imm_sel", int'(imm_sel), int'(ins[6:5]));
      if (st == 3'd3) begin
        case (ins[6:0])
          7'h33: begin check("exec_alu_src", alu_src, 0); check("exec_alu_op", alu_op, 2); end
          7'h13: begin check("exec_alu_src", alu_src, 1); check("exec_alu_op", alu_op, 2); end
          7'h03, 7'h23: begin check("exec_alu_src", alu_src, 1); check("exec_alu_op", alu_op, 0); end
          7'h63: check("exec_alu_op", alu_op, 1);
          default: check("exec_unexpected", 1, 0);
        endcase
      end
      r.irw   += int'(ir_write);
      r.pcw   += int'(pc_write);
      r.pcsrc += int'(pc_src);
      r.regw  += int'(reg_write);
      r.m2r   += int'(mem_to_reg);
      r.dreq  += int'(dmem_req);
      r.dwe   += int'(dmem_we);
      r.ill   += int'(illegal_instr);
      r.berr  += int'(bus_error);
      if (imem_req) icnt++;
      if (dmem_req) dcnt++;
      @(posedge clk);
      @(negedge clk);
      r.cycles++;
      if (state == 3'd0 || (state == 3'd1 && st != 3'd1)) done = 1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check("episode_done", int'(done), 1);
    r.idle = int'(state == 3'd0);
    d = instret - i0;
    r.ret = int'(d);
  endtask

  task automatic compare_res(input res_t a, input res_t e);
    check("cycles", a.cycles, e.cycles);
    check("ir_write_cnt", a.irw, e.irw);
    check("pc_write_cnt", a.pcw, e.pcw);
    check("pc_src_cnt", a.pcsrc, e.pcsrc);
    check("reg_write_cnt", a.regw, e.regw);
    check("mem_to_reg_cnt", a.m2r, e.m2r);
    check("dmem_req_cnt", a.dreq, e.dreq);
    check("dmem_we_cnt", a.dwe, e.dwe);
    check("illegal_cnt", a.ill, e.ill);
    check("bus_error_cnt", a.berr, e.berr);
    check("retired", a.ret, e.ret);
    check("ended_idle", a.idle, e.idle);
  endtask

  task automatic finish_episode(input res_t e);
    exp_instret = (exp_instret + e.ret) % (1 << CW);
    check("instret", int'(instret), exp_instret);
    if (e.idle != 0) begin
      @(negedge clk);
      check("idle_to_fetch", int'(state), 1);
    end
  endtask

  initial begin
    res_t r, m;
    logic [31:0] rnd, ins;
    logic [6:0] opc;
    logic [2:0] f3;
    int di, dd;
    bit z;

    vecs[0]  = mk(32'h00B50533, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(32'h0005B503, 0, 0, 3, 8, 1, 1, 0, 1, 1, 4, 0, 0, 0, 1, 0);
    vecs[2]  = mk(32'h00B50463, 1, 0, 0, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[3]  = mk(32'h00B50463, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[4]  = mk(32'h0000007F, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(32'h00B50533, 0, 4, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[6]  = mk(32'h00B50533, 0, 3, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[7]  = mk(32'h00B53023, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    vecs[8]  = mk(32'h00B53023, 0, 0, 4, 7, 1, 1, 0, 0, 0, 4, 3, 0, 1, 0, 1);
    vecs[9]  = mk(32'h00150513, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[10] = mk(32'h00B51463, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mk(32'h0005B503, 0, 0, 4, 7, 1, 1, 0, 0, 0, 4, 0, 0, 1, 0, 1);

    reset_n = 1'b0; instruction = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    check("reset_state", int'(state), 0);
    check("reset_instret", int'(instret), 0);
    check("reset_outputs", int'({imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write,
                                 alu_src, alu_op, mem_to_reg, illegal_instr, bus_error, imm_sel}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("fetch_after_idle", int'(state), 1);

    run_episode(32'h00B50533, 0, 0, 0, r);
    check("rtype_trace_len", trace.size(), 4);
    if (trace.size() == 4) begin
      check("rtype_trace0", trace[0], 1);
      check("rtype_trace1", trace[1], 2);
      check("rtype_trace2", trace[2], 3);
      check("rtype_trace3", trace[3], 5);
    end
    check("rtype_back_to_fetch", int'(state), 1);
    check("rtype_reg_write", r.regw, 1);
    exp_instret = 1;
    check("rtype_instret", int'(instret), 1);

    for (int i = 0; i < 12; i++) begin
      run_episode(vecs[i].ins, vecs[i].z, vecs[i].di, vecs[i].dd, r);
      compare_res(r, vecs[i].exp);
      finish_episode(vecs[i].exp);
    end

    for (int n = 0; n < 150; n++) begin
      rnd = $urandom();
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: opc = 7'h33;
        1: opc = 7'h13;
        2: opc = 7'h03;
        3: opc = 7'h23;
        4: begin opc = 7'h63; f3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b001; end
        default: begin
          opc = 7'($urandom_range(0, 127));
          while (is_legal(opc)) opc = 7'($urandom_range(0, 127));
        end
      endcase
      ins = {rnd[31:15], f3, rnd[11:7], opc};
      z  = 1'($urandom_range(0, 1));
      di = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 1) : $urandom_range(0, T - 1);
      dd = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 1) : $urandom_range(0, T - 1);
      m = model(ins, z, di, dd);
      run_episode(ins, z, di, dd, r);
      compare_res(r, m);
      finish_episode(m);
    end

    instruction = 32'h00B53023;
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    for (int k = 0; k < 10 && state != 3'd4; k++) begin
      @(negedge clk);
      imem_ready = 1'b0;
    end
    #1;
    check("store_reach_mem", int'(state), 4);
    check("store_mem_req", int'(dmem_req), 1);
    check("store_mem_we", int'(dmem_we), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_dmem_req", int'(dmem_req), 0);
    check("rst_dmem_we", int'(dmem_we), 0);
    check("rst_state", int'(state), 0);
    check("rst_writes", int'({ir_write, pc_write, reg_write, imem_req}), 0);
    check("rst_instret", int'(instret), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_restart_fetch", int'(state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
